result_deframer: RTL and testbench

RESULT_DEFRAMER -- requirements
Module: result_deframer

---
 rtl/parameters.sv | 36 +++
 rtl/deserializer.sv | 65 ++++++
 rtl/result_deframer.sv | 192 +++++++++++++++++++
 tb/tb_result_deframer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parameters.sv
// rtl/parameters.sv - shared frame constants and correction-word sizing helpers
//
// Purpose: constants common to every stage that handles decoder result
// frames, plus the derivation of correction bits/bytes per round.
// Contents:
//   HDR_LEN          header bytes per frame (iterations, cycles hi, cycles lo)
//   BYTE_W           stream byte width
//   corr_bits()      correction bits per round for a given lattice
//   corr_bytes()     stream bytes carrying one round
//   deframer_state_e result deframer FSM states
package parameters;

  localparam int HDR_LEN = 3;
  localparam int BYTE_W  = 8;

  function automatic int corr_bits(input int grid_x, input int grid_z);
    return 3 * (grid_x - 1) * grid_z + grid_z + 1;
  endfunction

  function automatic int corr_bytes(input int c_bits);
    return (c_bits + BYTE_W - 1) >> 3;
  endfunction

  function automatic int frame_bytes(input int c_bits, input int rounds);
    return HDR_LEN + corr_bytes(c_bits) * rounds;
  endfunction

  typedef enum logic [2:0] {
    HDR_ITER   = 3'd0,
    HDR_CYC_HI = 3'd1,
    HDR_CYC_LO = 3'd2,
    PAYLOAD    = 3'd3,
    EMIT       = 3'd4
  } deframer_state_e;

endpackage

// File: rtl/deserializer.sv
// rtl/deserializer.sv - narrow-to-wide word assembler, first byte least significant
//
// Purpose: collects NARROW_WIDTH-bit slices into one WIDE_WIDTH-bit word.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clear          drop any partial word and restart at slice 0
//   in_data        narrow slice
//   in_load        slice accepted this cycle
//   word_data      assembled word including the slice being loaded now
//   word_done      the slice being loaded completes the word
module deserializer #(
  parameter int WIDE_WIDTH   = 11,
  parameter int NARROW_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [NARROW_WIDTH-1:0] in_data,
  input  logic                    in_load,
  output logic [WIDE_WIDTH-1:0]   word_data,
  output logic                    word_done
);

  localparam int N_SLICES = (WIDE_WIDTH + NARROW_WIDTH - 1) / NARROW_WIDTH;
  localparam int CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam int ASM_W    = N_SLICES * NARROW_WIDTH;

  logic [ASM_W-1:0] asm_q, asm_d, asm_merged;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  int unsigned      base;

  always_comb begin
    base       = 32'(cnt_q) * NARROW_WIDTH;
    asm_merged = asm_q;
    if (in_load) begin
      asm_merged[base +: NARROW_WIDTH] = in_data;
    end
    word_done = in_load && (cnt_q == CNT_W'(N_SLICES - 1));
    // Bits above WIDE_WIDTH in the last slice are dropped here.
    word_data = asm_merged[WIDE_WIDTH-1:0];

    asm_d = asm_q;
    cnt_d = cnt_q;
    // Completing a word also empties the register so the next word starts
    // from zero and short words never inherit stale upper bits.
    if (clear || word_done) begin
      asm_d = '0;
      cnt_d = '0;
    end else if (in_load) begin
      asm_d = asm_merged;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/result_deframer.sv
// rtl/result_deframer.sv - splits decoder result frames into header fields and correction rounds
//
// Purpose: parses frames of {iterations, cycles[15:8], cycles[7:0],
// GRID_WIDTH_U rounds of B bytes} and presents one correction word per round.
// Ports:
//   clk, reset_n                          clock, asynchronous active-low reset
//   input_data/input_valid/input_ready    byte stream in
//   corr_data/corr_round/corr_last        correction word, round index, last round
//   corr_valid/corr_ready                 correction handshake
//   hdr_iterations/hdr_cycles/hdr_valid   header fields, pulse on update
//   frame_count                           completed frames, saturating
//   max_iterations                        largest iteration count since reset
module result_deframer
  import parameters::*;
#(
  parameter  int GRID_WIDTH_X            = 4,
  parameter  int GRID_WIDTH_Z            = 1,
  parameter  int GRID_WIDTH_U            = 3,
  parameter  int ITERATION_COUNTER_WIDTH = 8,
  localparam int C                       = corr_bits(GRID_WIDTH_X, GRID_WIDTH_Z),
  localparam int RW                      = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [7:0]                         input_data,
  input  logic                               input_valid,
  output logic                               input_ready,
  output logic [C-1:0]                       corr_data,
  output logic [RW-1:0]                      corr_round,
  output logic                               corr_last,
  output logic                               corr_valid,
  input  logic                               corr_ready,
  output logic [ITERATION_COUNTER_WIDTH-1:0] hdr_iterations,
  output logic [15:0]                        hdr_cycles,
  output logic                               hdr_valid,
  output logic [15:0]                        frame_count,
  output logic [ITERATION_COUNTER_WIDTH-1:0] max_iterations
);

  localparam int IW = ITERATION_COUNTER_WIDTH;

  deframer_state_e state_q, state_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [7:0]      cyc_hi_q, cyc_hi_d;
  logic [IW-1:0]   hdr_iterations_q, hdr_iterations_d;
  logic [15:0]     hdr_cycles_q, hdr_cycles_d;
  logic            hdr_valid_q, hdr_valid_d;
  logic [C-1:0]    corr_data_q, corr_data_d;
  logic [RW-1:0]   corr_round_q, corr_round_d;
  logic            corr_last_q, corr_last_d;
  logic            corr_valid_q, corr_valid_d;
  logic [RW-1:0]   round_q, round_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [IW-1:0]   max_iterations_q, max_iterations_d;

  logic            accept;
  logic            asm_clear;
  logic            asm_load;
  logic [C-1:0]    asm_word;
  logic            asm_done;

  // Stalling only ever happens in EMIT, so readiness depends on state alone.
  assign input_ready = (state_q != EMIT);
  assign accept      = input_valid && input_ready;
  assign asm_clear   = accept && (state_q == HDR_CYC_LO);
  assign asm_load    = accept && (state_q == PAYLOAD);

  deserializer #(
    .WIDE_WIDTH  (C),
    .NARROW_WIDTH(BYTE_W)
  ) u_deserializer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (asm_clear),
    .in_data  (input_data),
    .in_load  (asm_load),
    .word_data(asm_word),
    .word_done(asm_done)
  );

  always_comb begin
    state_d          = state_q;
    iter_d           = iter_q;
    cyc_hi_d         = cyc_hi_q;
    hdr_iterations_d = hdr_iterations_q;
    hdr_cycles_d     = hdr_cycles_q;
    hdr_valid_d      = 1'b0;
    corr_data_d      = corr_data_q;
    corr_round_d     = corr_round_q;
    corr_last_d      = corr_last_q;
    corr_valid_d     = corr_valid_q;
    round_d          = round_q;
    frame_count_d    = frame_count_q;
    max_iterations_d = max_iterations_q;

    // Compares against the published header, i.e. one cycle after it lands.
    if (hdr_valid_q && (hdr_iterations_q > max_iterations_q)) begin
      max_iterations_d = hdr_iterations_q;
    end

    case (state_q)
      HDR_ITER: begin
        if (accept) begin
          iter_d  = input_data[IW-1:0];
          state_d = HDR_CYC_HI;
        end
      end
      HDR_CYC_HI: begin
        if (accept) begin
          cyc_hi_d = input_data;
          state_d  = HDR_CYC_LO;
        end
      end
      HDR_CYC_LO: begin
        if (accept) begin
          hdr_iterations_d = iter_q;
          hdr_cycles_d     = {cyc_hi_q, input_data};
          hdr_valid_d      = 1'b1;
          round_d          = '0;
          state_d          = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (asm_done) begin
          corr_data_d  = asm_word;
          corr_round_d = round_q;
          corr_last_d  = (round_q == RW'(GRID_WIDTH_U - 1));
          corr_valid_d = 1'b1;
          state_d      = EMIT;
        end
      end
      EMIT: begin
        if (corr_valid_q && corr_ready) begin
          corr_valid_d = 1'b0;
          if (!corr_last_q) begin
            round_d = round_q + 1'b1;
            state_d = PAYLOAD;
          end else begin
            if (frame_count_q != 16'hFFFF) begin
              frame_count_d = frame_count_q + 16'd1;
            end
            state_d = HDR_ITER;
          end
        end
      end
      default: state_d = HDR_ITER;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= HDR_ITER;
      iter_q           <= '0;
      cyc_hi_q         <= '0;
      hdr_iterations_q <= '0;
      hdr_cycles_q     <= '0;
      hdr_valid_q      <= 1'b0;
      corr_data_q      <= '0;
      corr_round_q     <= '0;
      corr_last_q      <= 1'b0;
      corr_valid_q     <= 1'b0;
      round_q          <= '0;
      frame_count_q    <= '0;
      max_iterations_q <= '0;
    end else begin
      state_q          <= state_d;
      iter_q           <= iter_d;
      cyc_hi_q         <= cyc_hi_d;
      hdr_iterations_q <= hdr_iterations_d;
      hdr_cycles_q     <= hdr_cycles_d;
      hdr_valid_q      <= hdr_valid_d;
      corr_data_q      <= corr_data_d;
      corr_round_q     <= corr_round_d;
      corr_last_q      <= corr_last_d;
      corr_valid_q     <= corr_valid_d;
      round_q          <= round_d;
      frame_count_q    <= frame_count_d;
      max_iterations_q <= max_iterations_d;
    end
  end

  assign corr_data      = corr_data_q;
  assign corr_round     = corr_round_q;
  assign corr_last      = corr_last_q;
  assign corr_valid     = corr_valid_q;
  assign hdr_iterations = hdr_iterations_q;
  assign hdr_cycles     = hdr_cycles_q;
  assign hdr_valid      = hdr_valid_q;
  assign frame_count    = frame_count_q;
  assign max_iterations = max_iterations_q;

endmodule

// File: tb/tb_result_deframer.sv
// tb/tb_result_deframer.sv - scoreboard bench for result_deframer with default parameters
module tb_result_deframer;

  // Default lattice: 11 correction bits, 2 bytes per round, 3 rounds.
  localparam int U_ROUNDS = 3;

  typedef struct packed {
    logic [10:0] data;
    logic [1:0]  round;
    logic        last;
  } corr_exp_t;

  typedef struct packed {
    logic [7:0]  iters;
    logic [15:0] cycles;
  } hdr_exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  input_data = 8'h00;
  logic        input_valid = 1'b0;
  logic        input_ready;
  logic [10:0] corr_data;
  logic [1:0]  corr_round;
  logic        corr_last;
  logic        corr_valid;
  logic        corr_ready = 1'b0;
  logic [7:0]  hdr_iterations;
  logic [15:0] hdr_cycles;
  logic        hdr_valid;
  logic [15:0] frame_count;
  logic [7:0]  max_iterations;

  result_deframer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .input_data    (input_data),
    .input_valid   (input_valid),
    .input_ready   (input_ready),
    .corr_data     (corr_data),
    .corr_round    (corr_round),
    .corr_last     (corr_last),
    .corr_valid    (corr_valid),
    .corr_ready    (corr_ready),
    .hdr_iterations(hdr_iterations),
    .hdr_cycles    (hdr_cycles),
    .hdr_valid     (hdr_valid),
    .frame_count   (frame_count),
    .max_iterations(max_iterations)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  corr_exp_t   corr_q[$];
  hdr_exp_t    hdr_q[$];
  int          hs_times[$];
  int          fc_model = 0;
  logic [7:0]  max_model = 8'h00;
  int          rdy_mode = 0;
  int          stall_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // corr_ready policy: 0 always ready, 1 random, 2 never, 3 hold low for 10 valid cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: corr_ready = 1'b1;
        1: corr_ready = 1'($urandom_range(1));
        2: corr_ready = 1'b0;
        default: begin
          if (corr_valid && stall_cnt < 10) begin
            corr_ready = 1'b0;
            stall_cnt++;
          end else begin
            corr_ready = (stall_cnt >= 10);
          end
        end
      endcase
    end
  end

  // Monitor: handshakes complete on the next posedge, so judge them mid-cycle.
  initial begin
    logic      prev_stall;
    corr_exp_t held;
    corr_exp_t e;
    hdr_exp_t  h;
    prev_stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (corr_valid) check("ready_low_in_emit", 32'(input_ready), 32'd0);
      if (prev_stall) check("corr_hold", 32'({corr_data, corr_round, corr_last}), 32'(held));
      if (corr_valid && corr_ready) begin
        hs_times.push_back(cyc);
        if (corr_q.size() == 0) begin
          check("unexpected_corr", 32'd1, 32'd0);
        end else begin
          e = corr_q.pop_front();
          check("corr_word", 32'({corr_data, corr_round, corr_last}), 32'(e));
          if (e.last && fc_model < 16'hFFFF) fc_model++;
        end
      end
      prev_stall = corr_valid && !corr_ready;
      held = '{data: corr_data, round: corr_round, last: corr_last};
      if (hdr_valid) begin
        if (hdr_q.size() == 0) begin
          check("unexpected_hdr", 32'd1, 32'd0);
        end else begin
          h = hdr_q.pop_front();
          check("hdr_fields", 32'({hdr_iterations, hdr_cycles}), 32'(h));
          if (h.iters > max_model) max_model = h.iters;
        end
      end
    end
  end

  task automatic drive_byte(input logic [7:0] b, input int gap_pct);
    int budget;
    logic taken;
    while (int'($urandom_range(99)) < gap_pct) begin
      input_valid = 1'b0;
      input_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    input_data  = b;
    input_valid = 1'b1;
    budget = 0;
    taken  = 1'b0;
    while (!taken && budget < 2000) begin
      @(negedge clk);
      taken = input_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!taken) check("byte_accept_timeout", 32'd0, 32'd1);
    input_valid = 1'b0;
  endtask

  // Sends header plus the first n_pay payload bytes; only complete rounds are expected.
  task automatic send_frame(input logic [7:0] it, input logic [15:0] cy,
                            input logic [47:0] pay, input int n_pay, input int gap_pct);
    logic [15:0] w;
    hdr_q.push_back('{iters: it, cycles: cy});
    if (n_pay == 2 * U_ROUNDS) begin
      for (int r = 0; r < U_ROUNDS; r++) begin
        w = pay[16*r +: 16];
        corr_q.push_back('{data: w[10:0], round: 2'(r), last: (r == U_ROUNDS - 1)});
      end
    end
    drive_byte(it, gap_pct);
    drive_byte(cy[15:8], gap_pct);
    drive_byte(cy[7:0], gap_pct);
    for (int k = 0; k < n_pay; k++) drive_byte(pay[8*k +: 8], gap_pct);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((corr_q.size() != 0 || hdr_q.size() != 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 2000) check("drain_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_corr_valid"}, 32'(corr_valid), 32'd0);
    check({tag, "_hdr_valid"}, 32'(hdr_valid), 32'd0);
    check({tag, "_corr_fields"}, 32'({corr_data, corr_round, corr_last}), 32'd0);
    check({tag, "_hdr_fields"}, 32'({hdr_iterations, hdr_cycles}), 32'd0);
    check({tag, "_counters"}, 32'({frame_count, max_iterations}), 32'd0);
    check({tag, "_input_ready"}, 32'(input_ready), 32'd1);
  endtask

  initial begin
    logic [47:0] pay;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_state("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(input_ready), 32'd1);

    // Reference frame at full rate.
    rdy_mode = 0;
    pay = {8'h04, 8'h00, 8'h03, 8'hFF, 8'h07, 8'hA3};
    hs_times.delete();
    send_frame(8'h05, 16'd300, pay, 6, 0);
    drain();
    check("frame_count_1", 32'(frame_count), 32'd1);
    check("hs_count", 32'(hs_times.size()), 32'd3);
    if (hs_times.size() == 3) begin
      check("round_rate_0_1", 32'(hs_times[1] - hs_times[0]), 32'd3);
      check("round_rate_1_2", 32'(hs_times[2] - hs_times[1]), 32'd3);
    end

    // Same frame with the sink stalled for 10 cycles on the first word.
    stall_cnt = 0;
    rdy_mode = 3;
    send_frame(8'h05, 16'd300, pay, 6, 0);
    drain();
    check("stall_count", 32'(stall_cnt), 32'd10);
    check("frame_count_2", 32'(frame_count), 32'(fc_model));

    // Back-to-back frames, larger iteration count first.
    rdy_mode = 0;
    send_frame(8'h09, 16'h1234, 48'h0102_0304_0506, 6, 0);
    drain();
    check("max_after_9", 32'(max_iterations), 32'd9);
    send_frame(8'h04, 16'hBEEF, 48'hFFEE_DDCC_BBAA, 6, 0);
    drain();
    check("max_after_4", 32'(max_iterations), 32'd9);
    check("frame_count_4", 32'(frame_count), 32'd4);

    // Reset after five bytes while the first round sits in EMIT.
    rdy_mode = 2;
    send_frame(8'h33, 16'h0102, 48'h0000_0000_5A5A, 2, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("midreset");
    corr_q.delete();
    hdr_q.delete();
    fc_model = 0;
    max_model = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_mode = 0;
    send_frame(8'h07, 16'h00FF, 48'h0807_0605_0403, 6, 0);
    drain();
    check("frame_count_after_reset", 32'(frame_count), 32'd1);
    check("max_after_reset", 32'(max_iterations), 32'd7);

    // Random gaps and random sink stalls.
    rdy_mode = 1;
    for (int f = 0; f < 1000; f++) begin
      send_frame(8'($urandom), 16'($urandom), {16'($urandom), 32'($urandom)}, 6, 50);
    end
    drain();
    check("frame_count_random", 32'(frame_count), 32'(fc_model));
    check("max_random", 32'(max_iterations), 32'(max_model));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
